pipe_hazard_ctrl: RTL and testbench

- Central stall/flush controller for the five-stage DLX pipeline.
- Sequences the IF/ID, ID/EX, EX/MEM and MEM/WB register banks and the PC.
- Detects load-use hazards, flushes on taken branches, freezes the pipe during multi-cycle data-memory accesses with a timeout, and handles HALT.

---
 rtl/pipe_hazard_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush controller for the five-stage DLX pipeline
// Optional perf counters enabled by defining HAZ_PERF_CNT_EN.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic       id_halt,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_read,
    input  logic       ex_branch_taken,
    input  logic       mem_req,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       if_id_en,
    output logic       if_id_flush,
    output logic       id_ex_en,
    output logic       id_ex_flush,
    output logic       ex_mem_en,
    output logic       mem_wb_en,
    output logic       mem_wb_flush,
    output logic       mem_err,
    output logic       halted
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] perf_lu_stalls,
    output logic [CNT_W-1:0] perf_br_flushes,
    output logic [CNT_W-1:0] perf_mem_wait
`endif
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             mem_err_q, mem_err_d;

    logic             lu;
    logic             mem_stall;
    logic             tmo_hit;
    logic [CNT_W-1:0] tmo_inc;

    // r0 is hardwired zero, so a load targeting it never creates a dependency
    assign lu = ex_mem_read && (ex_rd != 5'd0) &&
                ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
    assign mem_stall = mem_req && !mem_ready;
    assign tmo_hit   = (tmo_cnt_q == TMO_LIM);
    assign tmo_inc   = (tmo_cnt_q == CNT_MAX) ? tmo_cnt_q : tmo_cnt_q + 1'b1;
    assign mem_err   = mem_err_q;

    always_comb begin
        state_d      = state_q;
        tmo_cnt_d    = tmo_cnt_q;
        mem_err_d    = mem_err_q;
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_en     = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_en    = 1'b0;
        mem_wb_en    = 1'b0;
        mem_wb_flush = 1'b0;
        halted       = 1'b0;

        case (state_q)
            RUN: begin
                if (mem_stall) begin
                    state_d   = MEM_WAIT;
                    tmo_cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
                end else if (ex_branch_taken) begin
                    {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (lu) begin
                    id_ex_en    = 1'b1;
                    id_ex_flush = 1'b1;
                    ex_mem_en   = 1'b1;
                    mem_wb_en   = 1'b1;
                end else if (id_halt) begin
                    {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
                    if_id_flush = 1'b1;
                    state_d     = HALT;
                end else begin
                    {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    mem_wb_en = 1'b1;
                    state_d   = RUN;
                    tmo_cnt_d = '0;
                end else if (tmo_hit) begin
                    mem_err_d    = 1'b1;
                    mem_wb_en    = 1'b1;
                    mem_wb_flush = 1'b1;
                    state_d      = RUN;
                    tmo_cnt_d    = '0;
                end else begin
                    tmo_cnt_d = tmo_inc;
                end
            end
            HALT: begin
                halted      = 1'b1;
                if_id_flush = 1'b1;
                // drain stages freeze on a stalled access, with the same abort rule as MEM_WAIT
                if (mem_stall) begin
                    if (tmo_hit) begin
                        mem_err_d    = 1'b1;
                        mem_wb_en    = 1'b1;
                        mem_wb_flush = 1'b1;
                        tmo_cnt_d    = '0;
                    end else begin
                        tmo_cnt_d = tmo_inc;
                    end
                end else begin
                    id_ex_en  = 1'b1;
                    ex_mem_en = 1'b1;
                    mem_wb_en = 1'b1;
                    tmo_cnt_d = '0;
                end
            end
            default: state_d = RUN;
        endcase

        if (!reset) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_en    = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            mem_wb_flush = 1'b1;
            halted       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= RUN;
            tmo_cnt_q <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmo_cnt_q <= tmo_cnt_d;
            mem_err_q <= mem_err_d;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic lu_ev, br_ev, mw_ev;

    assign br_ev = (state_q == RUN) && !mem_stall && ex_branch_taken;
    assign lu_ev = (state_q == RUN) && !mem_stall && !ex_branch_taken && lu;
    assign mw_ev = (state_q == MEM_WAIT);

    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_lu_stalls  <= '0;
            perf_br_flushes <= '0;
            perf_mem_wait   <= '0;
        end else begin
            if (lu_ev && perf_lu_stalls != CNT_MAX)  perf_lu_stalls  <= perf_lu_stalls + 1'b1;
            if (br_ev && perf_br_flushes != CNT_MAX) perf_br_flushes <= perf_br_flushes + 1'b1;
            if (mw_ev && perf_mem_wait != CNT_MAX)   perf_mem_wait   <= perf_mem_wait + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl (MEM_TIMEOUT=4)
module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 8;

    // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en, mem_wb_flush, mem_err, halted}
    localparam logic [9:0] E_RST   = 10'b0010100100;
    localparam logic [9:0] E_RUN   = 10'b1101011000;
    localparam logic [9:0] E_LU    = 10'b0001111000;
    localparam logic [9:0] E_BR    = 10'b1111111000;
    localparam logic [9:0] E_FRZ   = 10'b0000000000;
    localparam logic [9:0] E_MWB   = 10'b0000001000;
    localparam logic [9:0] E_ABORT = 10'b0000001100;
    localparam logic [9:0] E_HID   = 10'b1111011000;
    localparam logic [9:0] E_HLT   = 10'b0011011001;
    localparam logic [9:0] E_HFRZ  = 10'b0010000001;
    localparam logic [9:0] E_HABRT = 10'b0010001101;
    localparam logic [9:0] ERR     = 10'b0000000010;

    logic clk = 1'b0;
    logic reset;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic id_use_rs1, id_use_rs2, id_halt, ex_mem_read, ex_branch_taken, mem_req, mem_ready;
    logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en;
    logic mem_wb_en, mem_wb_flush, mem_err, halted;
`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] perf_lu_stalls, perf_br_flushes, perf_mem_wait;
`endif

    int checks = 0;
    int errors = 0;
    string      tag_q[$];
    logic [9:0] exp_q[$];

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_halt(id_halt), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en),
        .mem_wb_en(mem_wb_en), .mem_wb_flush(mem_wb_flush), .mem_err(mem_err), .halted(halted)
`ifdef HAZ_PERF_CNT_EN
        , .perf_lu_stalls(perf_lu_stalls), .perf_br_flushes(perf_br_flushes),
        .perf_mem_wait(perf_mem_wait)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic idle();
        reset = 1'b1; id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        id_halt = 1'b0; ex_rd = 5'd0; ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic set_lu(input logic [4:0] rd);
        ex_mem_read = 1'b1; ex_rd = rd; id_rs1 = rd; id_use_rs1 = 1'b1;
    endtask

    // push expectation with the stimulus, pop it once outputs settle mid-cycle, then clock
    task automatic cyc(input string tag, input logic [9:0] exp);
        logic [9:0] got;
        tag_q.push_back(tag);
        exp_q.push_back(exp);
        #2;
        got = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
               mem_wb_en, mem_wb_flush, mem_err, halted};
        check(tag_q.pop_front(), 32'(got), 32'(exp_q.pop_front()));
        @(negedge clk);
    endtask

    initial begin
        idle();
        reset = 1'b0;
        @(negedge clk);
        cyc("reset", E_RST);
        idle();
        cyc("run_idle", E_RUN);

        set_lu(5'd5);                              cyc("lu_rs1", E_LU);
        idle();                                    cyc("lu_release", E_RUN);
        ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
                                                   cyc("lu_rs2", E_LU);
        idle(); set_lu(5'd0);                      cyc("lu_r0", E_RUN);
        idle(); set_lu(5'd9); id_use_rs1 = 1'b0;   cyc("lu_unused", E_RUN);
        idle(); set_lu(5'd9); ex_branch_taken = 1; cyc("br_over_lu", E_BR);
        idle(); mem_req = 1; mem_ready = 1;        cyc("mem_hit", E_RUN);

        idle(); mem_req = 1;                       cyc("mw_enter", E_FRZ);
        ex_branch_taken = 1'b1;                    cyc("mw_br_ignored", E_FRZ);
        ex_branch_taken = 1'b0;                    cyc("mw_wait", E_FRZ);
        mem_ready = 1'b1;                          cyc("mw_done", E_MWB);
        idle();                                    cyc("mw_resume", E_RUN);

        idle(); mem_req = 1; ex_branch_taken = 1;  cyc("mw_over_br", E_FRZ);
        mem_ready = 1'b1;                          cyc("mw_done2", E_MWB);
        idle(); ex_branch_taken = 1'b1;            cyc("br_reeval", E_BR);

        idle(); mem_req = 1;                       cyc("tmo_c0", E_FRZ);
        for (int i = 1; i < 4; i++)                cyc($sformatf("tmo_c%0d", i), E_FRZ);
        cyc("tmo_abort", E_ABORT);
        idle();                                    cyc("err_sticky1", E_RUN | ERR);
        cyc("err_sticky2", E_RUN | ERR);

        id_halt = 1'b1;                            cyc("halt_enter", E_HID | ERR);
        idle();                                    cyc("halt_drain", E_HLT | ERR);
        ex_branch_taken = 1'b1;                    cyc("halt_br", E_HLT | ERR);
        idle(); mem_req = 1;                       cyc("halt_mfrz", E_HFRZ | ERR);
        mem_ready = 1'b1;                          cyc("halt_mdone", E_HLT | ERR);
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++)                cyc($sformatf("halt_tmo%0d", i), E_HFRZ | ERR);
        cyc("halt_abort", E_HABRT | ERR);
        idle();                                    cyc("halt_stay", E_HLT | ERR);

        reset = 1'b0;                              cyc("reset2", E_RST | ERR);
        idle();                                    cyc("post_reset", E_RUN);

`ifdef HAZ_PERF_CNT_EN
        reset = 1'b0;                              cyc("perf_reset", E_RST);
        idle();
        check("perf_lu_clr", 32'(perf_lu_stalls), 32'd0);
        set_lu(5'd3);
        for (int i = 0; i < 300; i++)              cyc("perf_lu_cyc", E_LU);
        idle();
        check("perf_lu_sat", 32'(perf_lu_stalls), 32'd255);
        check("perf_br_zero", 32'(perf_br_flushes), 32'd0);
        mem_req = 1'b1;                            cyc("perf_mw0", E_FRZ);
        cyc("perf_mw1", E_FRZ);
        mem_ready = 1'b1;                          cyc("perf_mw2", E_MWB);
        check("perf_mem_wait", 32'(perf_mem_wait), 32'd2);
`endif

        if (tag_q.size() != 0) check("scoreboard_drain", 32'(tag_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
